// File: rtl/rob2w_commit.sv
// rtl/rob2w_commit.sv - dual-issue in-order commit buffer feeding a two-write-port register file
module rob2w_commit #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 3
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            flush,
    input  logic            alloc_x,
    input  logic            alloc_y,
    input  logic [4:0]      alloc_wnx,
    input  logic [4:0]      alloc_wny,
    input  logic            alloc_wex,
    input  logic            alloc_wey,
    output logic            alloc_rdy,
    output logic [TAGW-1:0] tag_x,
    output logic [TAGW-1:0] tag_y,
    input  logic            cmp_vx,
    input  logic            cmp_vy,
    input  logic [TAGW-1:0] cmp_tx,
    input  logic [TAGW-1:0] cmp_ty,
    input  logic [31:0]     cmp_dx,
    input  logic [31:0]     cmp_dy,
    output logic [4:0]      wnx,
    output logic [4:0]      wny,
    output logic [31:0]     dx,
    output logic [31:0]     dy,
    output logic            wex,
    output logic            wey,
    output logic            ret_x,
    output logic            ret_y,
    output logic [TAGW:0]   count,
    output logic            empty
);

    // Highest occupancy that still leaves room for a full pair.
    localparam logic [TAGW:0] ALLOC_LIMIT = (TAGW+1)'(DEPTH - 2);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] we;
    logic [4:0]       wn   [DEPTH];
    logic [31:0]      data [DEPTH];

    logic [TAGW-1:0]  head;
    logic [TAGW-1:0]  tail;
    logic [TAGW-1:0]  head1;
    logic [TAGW-1:0]  tail1;

    logic             alloc_go;
    logic             alloc_two;
    logic [TAGW:0]    n_alloc;
    logic [TAGW:0]    n_ret;

    assign head1 = head + 1'b1;
    assign tail1 = tail + 1'b1;

    assign tag_x = tail;
    assign tag_y = tail1;

    // Freed slots are only credited once count itself has dropped.
    assign alloc_rdy = (count <= ALLOC_LIMIT);
    assign empty     = (count == '0);

    assign alloc_go  = alloc_x & alloc_rdy;
    assign alloc_two = alloc_go & alloc_y;

    // Retire straight from registered state; no bypass from this cycle's completions.
    assign ret_x = valid[head] & done[head];
    assign ret_y = ret_x & valid[head1] & done[head1];

    assign wnx = wn[head];
    assign dx  = data[head];
    assign wex = ret_x & we[head] & (wn[head] != 5'd0);

    assign wny = wn[head1];
    assign dy  = data[head1];
    assign wey = ret_y & we[head1] & (wn[head1] != 5'd0);

    // Number of entries entering and leaving the buffer this cycle.
    always_comb begin
        n_alloc = '0;
        n_ret   = '0;
        if (alloc_two) begin
            n_alloc = (TAGW+1)'(2);
        end else if (alloc_go) begin
            n_alloc = (TAGW+1)'(1);
        end
        if (ret_y) begin
            n_ret = (TAGW+1)'(2);
        end else if (ret_x) begin
            n_ret = (TAGW+1)'(1);
        end
    end

    // Entry array and pointer update: flush beats everything, y completion beats x.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid <= '0;
            done  <= '0;
            we    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wn[i]   <= 5'd0;
                data[i] <= 32'd0;
            end
        end else if (flush) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cmp_vx && valid[cmp_tx]) begin
                done[cmp_tx] <= 1'b1;
                data[cmp_tx] <= cmp_dx;
            end
            if (cmp_vy && valid[cmp_ty]) begin
                done[cmp_ty] <= 1'b1;
                data[cmp_ty] <= cmp_dy;
            end
            if (ret_x) begin
                valid[head] <= 1'b0;
            end
            if (ret_y) begin
                valid[head1] <= 1'b0;
            end
            if (alloc_go) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                we[tail]    <= alloc_wex;
                wn[tail]    <= alloc_wnx;
            end
            if (alloc_two) begin
                valid[tail1] <= 1'b1;
                done[tail1]  <= 1'b0;
                we[tail1]    <= alloc_wey;
                wn[tail1]    <= alloc_wny;
            end
            head  <= head + n_ret[TAGW-1:0];
            tail  <= tail + n_alloc[TAGW-1:0];
            count <= count + n_alloc - n_ret;
        end
    end

endmodule
